// File: rtl/rally_sequencer.sv
// Serve/rally/point controller for the 16-LED tennis datapath: issues ball load/shift
// commands, schedules rally speed through the divider toggle value and keeps score.
module rally_sequencer #(
    parameter int                  TOGGLE_W    = 22,
    parameter logic [TOGGLE_W-1:0] TOGGLE_INIT = 22'h35E100,
    parameter logic [TOGGLE_W-1:0] TOGGLE_STEP = 22'h1FFFF,
    parameter logic [TOGGLE_W-1:0] TOGGLE_MIN  = 22'h0FFFFF,
    parameter int                  MISS_LIMIT  = 3,
    parameter int                  WIN_POINTS  = 3
) (
    input  logic                newclock,
    input  logic                reset,
    input  logic                hit_left,
    input  logic                hit_right,
    input  logic                ball_at_left,
    input  logic                ball_at_right,
    output logic                ball_load,
    output logic                ball_load_pos,
    output logic                ball_shift,
    output logic                ball_dir,
    output logic [TOGGLE_W-1:0] toggle_val,
    output logic [1:0]          score_left,
    output logic [1:0]          score_right,
    output logic                winner_valid,
    output logic                winner,
    output logic                server
);

    typedef enum logic [1:0] {SERVE, RALLY, MATCH_OVER} state_t;

    state_t              r_state, w_nextState;
    logic                r_server, w_server;
    logic                r_dir, w_dir;
    logic [1:0]          r_missCnt, w_missCnt;
    logic                r_ballLoad, w_ballLoad;
    logic                r_ballLoadPos, w_ballLoadPos;
    logic [TOGGLE_W-1:0] r_toggle, w_toggle;
    logic [1:0]          r_scoreLeft, w_scoreLeft;
    logic [1:0]          r_scoreRight, w_scoreRight;
    logic                r_winnerValid, w_winnerValid;
    logic                r_winner, w_winner;
    logic                r_pendingLoad;

    logic                w_atDest;
    logic                w_receiverHit;
    logic                w_serverHit;
    logic                w_award;
    logic                w_awardLeft;
    logic [1:0]          w_awardScore;
    logic [TOGGLE_W:0]   w_toggleDiff;
    logic [TOGGLE_W-1:0] w_toggleDec;

    assign w_atDest      = r_dir ? ball_at_left : ball_at_right;
    assign w_receiverHit = r_dir ? hit_left : hit_right;
    assign w_serverHit   = r_server ? hit_left : hit_right;
    assign w_awardLeft   = ~r_dir;
    assign w_awardScore  = (w_awardLeft ? r_scoreLeft : r_scoreRight) + 2'd1;

    // Extra borrow bit catches wrap-around before the floor compare.
    assign w_toggleDiff = {1'b0, r_toggle} - {1'b0, TOGGLE_STEP};
    assign w_toggleDec  = (w_toggleDiff[TOGGLE_W] || (w_toggleDiff[TOGGLE_W-1:0] < TOGGLE_MIN))
                          ? TOGGLE_MIN : w_toggleDiff[TOGGLE_W-1:0];

    always_ff @(posedge newclock or posedge reset) begin
        if (reset) begin
            r_state       <= SERVE;
            r_server      <= 1'b0;
            r_dir         <= 1'b1;
            r_missCnt     <= 2'd0;
            r_ballLoad    <= 1'b0;
            r_ballLoadPos <= 1'b0;
            r_toggle      <= TOGGLE_INIT;
            r_scoreLeft   <= 2'd0;
            r_scoreRight  <= 2'd0;
            r_winnerValid <= 1'b0;
            r_winner      <= 1'b0;
            r_pendingLoad <= 1'b1;
        end else begin
            r_state       <= w_nextState;
            r_server      <= w_server;
            r_dir         <= w_dir;
            r_missCnt     <= w_missCnt;
            r_ballLoad    <= w_ballLoad;
            r_ballLoadPos <= w_ballLoadPos;
            r_toggle      <= w_toggle;
            r_scoreLeft   <= w_scoreLeft;
            r_scoreRight  <= w_scoreRight;
            r_winnerValid <= w_winnerValid;
            r_winner      <= w_winner;
            r_pendingLoad <= 1'b0;
        end
    end

    // The first edge after reset release places the ball at the right end for the opening serve.
    always_comb begin
        w_nextState   = r_state;
        w_server      = r_server;
        w_dir         = r_dir;
        w_missCnt     = r_missCnt;
        w_ballLoad    = r_pendingLoad;
        w_ballLoadPos = r_pendingLoad ? 1'b0 : r_ballLoadPos;
        w_toggle      = r_toggle;
        w_scoreLeft   = r_scoreLeft;
        w_scoreRight  = r_scoreRight;
        w_winnerValid = r_winnerValid;
        w_winner      = r_winner;
        w_award       = 1'b0;

        case (r_state)
            SERVE: begin
                if (w_serverHit) begin
                    w_nextState = RALLY;
                    w_dir       = ~r_server;
                    w_missCnt   = 2'd0;
                    w_toggle    = TOGGLE_INIT;
                end
            end
            RALLY: begin
                if (w_atDest) begin
                    if (w_receiverHit) begin
                        w_dir     = ~r_dir;
                        w_missCnt = 2'd0;
                        w_toggle  = w_toggleDec;
                    end else begin
                        w_award = 1'b1;
                    end
                end else if (w_receiverHit) begin
                    if (int'(r_missCnt) + 1 >= MISS_LIMIT) begin
                        w_award = 1'b1;
                    end else if (r_missCnt != 2'b11) begin
                        w_missCnt = r_missCnt + 2'd1;
                    end
                end
            end
            MATCH_OVER: begin
                if (hit_left || hit_right) begin
                    w_nextState   = SERVE;
                    w_scoreLeft   = 2'd0;
                    w_scoreRight  = 2'd0;
                    w_winnerValid = 1'b0;
                    w_server      = 1'b0;
                    w_ballLoad    = 1'b1;
                    w_ballLoadPos = 1'b0;
                end
            end
            default: w_nextState = SERVE;
        endcase

        // Point goes to the sender; the receiver (loser) serves next from its own end.
        if (w_award) begin
            if (w_awardLeft) begin
                w_scoreLeft = w_awardScore;
            end else begin
                w_scoreRight = w_awardScore;
            end
            w_server      = r_dir;
            w_ballLoad    = 1'b1;
            w_ballLoadPos = r_dir;
            w_toggle      = TOGGLE_INIT;
            if (int'(w_awardScore) == WIN_POINTS) begin
                w_nextState   = MATCH_OVER;
                w_winnerValid = 1'b1;
                w_winner      = w_awardLeft;
            end else begin
                w_nextState = SERVE;
            end
        end
    end

    always_comb begin
        ball_shift = (r_state == RALLY) && !w_atDest;
        ball_dir   = r_dir;
    end

    assign ball_load     = r_ballLoad;
    assign ball_load_pos = r_ballLoadPos;
    assign toggle_val    = r_toggle;
    assign score_left    = r_scoreLeft;
    assign score_right   = r_scoreRight;
    assign winner_valid  = r_winnerValid;
    assign winner        = r_winner;
    assign server        = r_server;

endmodule
